regfile_wr_scoreboard: RTL and testbench

Parametrised destination-register tracker for the pipelined ARM register file. It decodes the write address into a registered one-hot write-enable bus, which generalises the fixed 3:8 decoder to ADDR_W:2^ADDR_W. It also keeps a pending-write bitmap for in-flight destinations, so decode-stage hazard checks and write-after-write stalls come from one block. It sits between decode (issue side) and writeback (retire side), and its wen bus drives the register file row enables directly.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/decoder_n.sv | 23 ++
 rtl/regfile_wr_scoreboard.sv | 108 ++++++++++
 tb/tb_regfile_wr_scoreboard.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Constants and types shared by the register file, the hazard unit and
//   the destination-register write scoreboard.
//   REG_ADDR_W : default register address width
//   XZR        : index of the hard-wired zero register
//   reg_addr_t : register address type at the default width
//   nregs()    : number of registers addressed by a given address width
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XZR        = 31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    function automatic int nregs(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/decoder_n.sv
// decoder_n
//   Combinational ADDR_W : 2**ADDR_W one-hot decoder with enable.
//   en     in   1               output is all-zero when low
//   addr   in   ADDR_W          index of the bit to set
//   onehot out  2**ADDR_W       one-hot (or zero) decode of addr
module decoder_n
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                       en,
    input  logic [ADDR_W-1:0]          addr,
    output logic [nregs(ADDR_W)-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_scoreboard.sv
// regfile_wr_scoreboard
//   Destination-register tracker for the pipelined register file. Keeps a
//   pending-write bitmap of in-flight destinations (issue sets, retire
//   clears, flush discards) and produces the registered one-hot row write
//   enable for the register file from the retire address.
//
//   clk           in   1       rising-edge clock
//   reset_n       in   1       asynchronous active-low reset
//   issue_valid   in   1       decode presents a destination write
//   issue_addr    in   ADDR_W  destination of the issuing instruction
//   issue_ready   out  1       combinational; issue accepted when valid && ready
//   retire_valid  in   1       writeback commits a register this cycle
//   retire_addr   in   ADDR_W  register being written back
//   flush         in   1       synchronous; drops all pending destinations
//   rd_addr_a/b   in   ADDR_W  source registers under hazard check
//   hazard_a/b    out  1       combinational; source has a pending write
//   pending       out  NREGS   registered scoreboard bitmap
//   wen           out  NREGS   registered one-hot row write enable
//   retire_err    out  1       one-cycle pulse: retire of a non-pending register
module regfile_wr_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int ZERO_REG  = XZR,
    parameter bit MASK_ZERO = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_addr,
    output logic                       issue_ready,
    input  logic                       retire_valid,
    input  logic [ADDR_W-1:0]          retire_addr,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          rd_addr_a,
    input  logic [ADDR_W-1:0]          rd_addr_b,
    output logic                       hazard_a,
    output logic                       hazard_b,
    output logic [nregs(ADDR_W)-1:0]   pending,
    output logic [nregs(ADDR_W)-1:0]   wen,
    output logic                       retire_err
);

    localparam int                NREGS     = nregs(ADDR_W);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic             issue_zero;
    logic             retire_zero;
    logic             issue_fire;
    logic             retire_eff;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    // The zero register is invisible to the scoreboard when masked: it never
    // sets, clears, raises hazards or generates a row enable.
    assign issue_zero  = MASK_ZERO && (issue_addr  == ZERO_ADDR);
    assign retire_zero = MASK_ZERO && (retire_addr == ZERO_ADDR);

    // WAW stall, with a bypass when the previous owner retires on this edge.
    assign issue_ready = issue_zero
                       || !pending[issue_addr]
                       || (retire_valid && (retire_addr == issue_addr));

    assign issue_fire = issue_valid && issue_ready && !issue_zero;
    assign retire_eff = retire_valid && !retire_zero;

    // No retire bypass on hazards: the register file writes through.
    assign hazard_a = pending[rd_addr_a];
    assign hazard_b = pending[rd_addr_b];

    // Flush outranks a same-edge issue, so the issue decode is gated here.
    decoder_n #(.ADDR_W(ADDR_W)) u_issue_dec (
        .en     (issue_fire && !flush),
        .addr   (issue_addr),
        .onehot (set_vec)
    );

    // Retire decode feeds both the pending clear and the row enable; a retire
    // on the flush edge still writes because writeback is past the flush.
    decoder_n #(.ADDR_W(ADDR_W)) u_retire_dec (
        .en     (retire_eff),
        .addr   (retire_addr),
        .onehot (clr_vec)
    );

    // Set is applied after clear so a same-address issue/retire leaves the
    // bit owned by the new instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wen        <= '0;
            retire_err <= 1'b0;
        end else begin
            wen        <= clr_vec;
            retire_err <= retire_eff && !pending[retire_addr];
        end
    end

endmodule

// File: tb/tb_regfile_wr_scoreboard.sv
module tb_regfile_wr_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        issue_valid, retire_valid, flush;
    logic [4:0]  issue_addr, retire_addr, rd_addr_a, rd_addr_b;
    logic        issue_ready, hazard_a, hazard_b, retire_err;
    logic [31:0] pending, wen;

    // second instance sharing the stimulus, zero register unmasked
    logic        nz_issue_ready, nz_hazard_a, nz_hazard_b, nz_retire_err;
    logic [31:0] nz_pending, nz_wen;

    // 3-bit address instance
    logic        s_issue_valid, s_retire_valid, s_flush;
    logic [2:0]  s_issue_addr, s_retire_addr, s_rd_addr_a, s_rd_addr_b;
    logic        s_issue_ready, s_hazard_a, s_hazard_b, s_retire_err;
    logic [7:0]  s_pending, s_wen;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pend;
        logic [31:0] wen;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_pend = '0;

    always #5 clk = ~clk;

    regfile_wr_scoreboard dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .retire_valid(retire_valid), .retire_addr(retire_addr), .flush(flush),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b),
        .pending(pending), .wen(wen), .retire_err(retire_err)
    );

    regfile_wr_scoreboard #(.MASK_ZERO(1'b0)) dut_nz (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(nz_issue_ready),
        .retire_valid(retire_valid), .retire_addr(retire_addr), .flush(flush),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .hazard_a(nz_hazard_a), .hazard_b(nz_hazard_b),
        .pending(nz_pending), .wen(nz_wen), .retire_err(nz_retire_err)
    );

    regfile_wr_scoreboard #(.ADDR_W(3), .MASK_ZERO(1'b0)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(s_issue_valid), .issue_addr(s_issue_addr), .issue_ready(s_issue_ready),
        .retire_valid(s_retire_valid), .retire_addr(s_retire_addr), .flush(s_flush),
        .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b),
        .hazard_a(s_hazard_a), .hazard_b(s_hazard_b),
        .pending(s_pending), .wen(s_wen), .retire_err(s_retire_err)
    );

    task automatic idle();
        issue_valid = 1'b0; issue_addr = '0; retire_valid = 1'b0; retire_addr = '0;
        flush = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    endtask

    // Called just after a falling edge with inputs applied: checks the
    // combinational outputs, pushes the expected next state, crosses the
    // rising edge and pops/compares against the registered outputs.
    task automatic step(input string tag);
        exp_t e;
        logic zi, zr, rdy;
        #1;
        zi  = (issue_addr == 5'd31);
        zr  = (retire_addr == 5'd31);
        rdy = zi || !m_pend[issue_addr] || (retire_valid && retire_addr == issue_addr);
        checks++;
        if (issue_ready !== rdy) begin
            errors++;
            $display("FAIL %s issue_ready: got %b want %b", tag, issue_ready, rdy);
        end
        checks++;
        if (hazard_a !== m_pend[rd_addr_a] || hazard_b !== m_pend[rd_addr_b]) begin
            errors++;
            $display("FAIL %s hazard: got a=%b b=%b want a=%b b=%b", tag, hazard_a, hazard_b,
                     m_pend[rd_addr_a], m_pend[rd_addr_b]);
        end
        e.pend = m_pend;
        e.wen  = '0;
        e.err  = 1'b0;
        if (retire_valid && !zr) begin
            e.wen[retire_addr]  = 1'b1;
            e.err               = !m_pend[retire_addr];
            e.pend[retire_addr] = 1'b0;
        end
        if (issue_valid && rdy && !zi) e.pend[issue_addr] = 1'b1;
        if (flush) e.pend = '0;
        m_pend = e.pend;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if (pending !== e.pend) begin
            errors++;
            $display("FAIL %s pending: got %h want %h", tag, pending, e.pend);
        end
        checks++;
        if (wen !== e.wen) begin
            errors++;
            $display("FAIL %s wen: got %h want %h", tag, wen, e.wen);
        end
        checks++;
        if (retire_err !== e.err) begin
            errors++;
            $display("FAIL %s retire_err: got %b want %b", tag, retire_err, e.err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        s_issue_valid = 1'b0; s_issue_addr = '0; s_retire_valid = 1'b0; s_retire_addr = '0;
        s_flush = 1'b0; s_rd_addr_a = '0; s_rd_addr_b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (pending !== '0 || wen !== '0 || retire_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got pend=%h wen=%h err=%b want 0", pending, wen, retire_err);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (issue_ready !== 1'b1 || hazard_a !== 1'b0 || hazard_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b ha=%b hb=%b want 1 0 0", issue_ready, hazard_a, hazard_b);
        end
        m_pend = '0;
    endtask

    task automatic test_issue_retire();
        idle(); issue_valid = 1'b1; issue_addr = 5'd3;
        step("issue_x3");
        idle(); rd_addr_a = 5'd3;
        checks++;
        #1;
        if (pending !== 32'h8 || hazard_a !== 1'b1) begin
            errors++;
            $display("FAIL x3_hazard: got pend=%h ha=%b want 00000008 1", pending, hazard_a);
        end
        step("hazard_x3");
        idle(); retire_valid = 1'b1; retire_addr = 5'd3;
        step("retire_x3");
        idle();
        step("after_retire_x3");
    endtask

    task automatic test_waw();
        idle(); issue_valid = 1'b1; issue_addr = 5'd5;
        step("issue_x5");
        step("waw_stall_x5");
        retire_valid = 1'b1; retire_addr = 5'd5;
        step("waw_bypass_x5");
        idle(); retire_valid = 1'b1; retire_addr = 5'd5;
        step("cleanup_x5");
        idle();
        step("after_x5");
    endtask

    task automatic test_zero_reg();
        idle(); issue_valid = 1'b1; issue_addr = 5'd31;
        step("issue_xzr");
        idle(); rd_addr_a = 5'd31;
        #1;
        checks++;
        if (nz_pending[31] !== 1'b1 || nz_hazard_a !== 1'b1) begin
            errors++;
            $display("FAIL nomask_issue_x31: got pend31=%b ha=%b want 1 1", nz_pending[31], nz_hazard_a);
        end
        step("hazard_xzr");
        idle(); retire_valid = 1'b1; retire_addr = 5'd31;
        step("retire_xzr");
        checks++;
        if (nz_wen !== 32'h8000_0000 || nz_retire_err !== 1'b0 || nz_pending !== '0) begin
            errors++;
            $display("FAIL nomask_retire_x31: got wen=%h err=%b pend=%h want 80000000 0 0",
                     nz_wen, nz_retire_err, nz_pending);
        end
        idle();
        step("after_xzr");
    endtask

    task automatic test_flush();
        idle(); issue_valid = 1'b1; issue_addr = 5'd1;
        step("issue_x1");
        issue_addr = 5'd2;
        step("issue_x2");
        idle(); flush = 1'b1; issue_valid = 1'b1; issue_addr = 5'd4;
        retire_valid = 1'b1; retire_addr = 5'd1;
        step("flush_edge");
        idle();
        step("after_flush");
    endtask

    task automatic test_retire_err();
        idle(); retire_valid = 1'b1; retire_addr = 5'd7;
        step("retire_x7_unpending");
        idle();
        step("after_x7");
    endtask

    task automatic test_async_reset();
        idle(); issue_valid = 1'b1;
        issue_addr = 5'd1; step("ar_issue_x1");
        issue_addr = 5'd2; step("ar_issue_x2");
        idle(); retire_valid = 1'b1; retire_addr = 5'd9; issue_valid = 1'b1; issue_addr = 5'd9;
        step("ar_issue_x9");
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (pending !== '0 || wen !== '0 || retire_err !== 1'b0 || nz_pending !== '0) begin
            errors++;
            $display("FAIL async_reset: got pend=%h wen=%h err=%b want 0 0 0", pending, wen, retire_err);
        end
        m_pend = '0;
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        step("after_async_reset");
    endtask

    task automatic test_back_to_back();
        int a;
        for (int i = 0; i < 60; i++) begin
            idle();
            issue_valid  = ($urandom_range(0, 1) == 1);
            retire_valid = ($urandom_range(0, 1) == 1);
            flush        = ($urandom_range(0, 9) == 0);
            a = $urandom_range(0, 8); issue_addr  = (a == 8) ? 5'd31 : 5'(a);
            a = $urandom_range(0, 8); retire_addr = (a == 8) ? 5'd31 : 5'(a);
            a = $urandom_range(0, 8); rd_addr_a   = (a == 8) ? 5'd31 : 5'(a);
            a = $urandom_range(0, 8); rd_addr_b   = (a == 8) ? 5'd31 : 5'(a);
            step("random");
        end
        idle();
        flush = 1'b1;
        step("random_flush");
        idle();
    endtask

    task automatic test_sweep3();
        logic [7:0] exp_wen;
        for (int a = 0; a < 8; a++) begin
            s_issue_valid = 1'b1; s_issue_addr = 3'(a);
            s_retire_valid = 1'b0;
            @(posedge clk); #1;
            checks++;
            exp_wen = 8'h01 << a;
            if (s_pending !== exp_wen) begin
                errors++;
                $display("FAIL sweep3_pending_%0d: got %h want %h", a, s_pending, exp_wen);
            end
            @(negedge clk);
            s_issue_valid = 1'b0;
            s_retire_valid = 1'b1; s_retire_addr = 3'(a);
            @(posedge clk); #1;
            checks++;
            if (s_wen !== exp_wen || s_pending !== 8'h00 || s_retire_err !== 1'b0) begin
                errors++;
                $display("FAIL sweep3_wen_%0d: got wen=%h pend=%h err=%b want %h 00 0",
                         a, s_wen, s_pending, s_retire_err, exp_wen);
            end
            @(negedge clk);
            s_retire_valid = 1'b0;
        end
        @(posedge clk); #1;
        checks++;
        if (s_wen !== 8'h00) begin
            errors++;
            $display("FAIL sweep3_idle_wen: got %h want 00", s_wen);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_issue_retire();
        test_waw();
        test_zero_reg();
        test_flush();
        test_retire_err();
        test_async_reset();
        test_back_to_back();
        test_sweep3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
